// File: rtl/gate_event_arbiter.sv
// gate_event_arbiter
//
// Turns asynchronous gate levels into a stream of edge events (note-on /
// note-off) presented on a valid/ready output. Each gate input is
// synchronized, optionally debounced, and edge-detected against its
// previous accepted level. Every channel owns a single pending slot; a new
// edge into an occupied slot replaces the stored polarity and is counted as
// a drop. Pending slots are served round-robin into a one-deep output
// register.
//
// Optional feature: define GATE_DEBOUNCE_EN to insert a per-channel
// stable-count filter of DEBOUNCE_CYCLES cycles between the synchronizer
// and the edge detector. Without it the accepted level is the synchronizer
// output and no counters exist.
//
// Ports
//   mclk        in   1         clock, all logic on the rising edge
//   rst         in   1         synchronous active-high reset
//   gate_in     in   CHANNELS  asynchronous gate levels, bit i = channel i
//   ev_valid    out  1         event available
//   ev_ready    in   1         consumer takes the event when high with ev_valid
//   ev_chan     out  3         channel of the presented event (upper bits zero)
//   ev_rise     out  1         1 = rising edge, 0 = falling edge
//   gate_level  out  CHANNELS  accepted level per channel
//   drop_count  out  8         overwritten events, saturates at 255

module gate_event_arbiter #(
    parameter int   CHANNELS        = 4,
    parameter logic INIT_LEVEL      = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 16
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] gate_in,
    output logic                ev_valid,
    input  logic                ev_ready,
    output logic [2:0]          ev_chan,
    output logic                ev_rise,
    output logic [CHANNELS-1:0] gate_level,
    output logic [7:0]          drop_count
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(CHANNELS - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer and edge history
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] s1_q, s1_d;
    logic [CHANNELS-1:0] s2_q, s2_d;
    logic [CHANNELS-1:0] hist_q, hist_d;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] edge_det;

    always_comb begin
        s1_d   = gate_in;
        s2_d   = s1_q;
        hist_d = level;
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            s1_q   <= INIT_VEC;
            s2_q   <= INIT_VEC;
            hist_q <= INIT_VEC;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            hist_q <= hist_d;
        end
    end

`ifdef GATE_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Stable-count filter: the accepted level follows s2 only after s2 has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles. Any cycle of
    // agreement restarts the count, so short pulses never get through.
    // ------------------------------------------------------------------
    localparam logic [7:0] DB_TC = 8'(DEBOUNCE_CYCLES);

    logic [CHANNELS-1:0]      db_level_q, db_level_d;
    logic [CHANNELS-1:0][7:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = db_cnt_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s2_q[i] == db_level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] + 8'd1 == DB_TC) begin
                db_level_d[i] = s2_q[i];
                db_cnt_d[i]   = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 8'd1;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            db_level_q <= INIT_VEC;
            db_cnt_q   <= '0;
        end else begin
            db_level_q <= db_level_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign level = db_level_q;
`else
    // No filter: the synchronizer output is the accepted level and the
    // debounce length has no effect.
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^8'(DEBOUNCE_CYCLES);

    assign level = s2_q;
`endif

    assign edge_det   = level ^ hist_q;
    assign gate_level = level;

    // ------------------------------------------------------------------
    // Output register, pending slots, round-robin grant
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] pend_v_q, pend_v_d;
    logic [CHANNELS-1:0] pend_pol_q, pend_pol_d;
    logic                ev_valid_q, ev_valid_d;
    logic [2:0]          ev_chan_q, ev_chan_d;
    logic                ev_rise_q, ev_rise_d;
    logic [IDX_W-1:0]    last_q, last_d;
    logic [7:0]          drop_q, drop_d;

    logic                load;
    logic                gnt_any;
    logic [IDX_W-1:0]    gnt_idx;
    logic [CHANNELS-1:0] gnt_vec;
    logic [3:0]          drop_n;
    logic [8:0]          drop_sum;

    // The output register may take a new event whenever it is empty or its
    // current event is being accepted this cycle.
    assign load = !ev_valid_q || ev_ready;

    // First pending channel searching upward from last granted + 1.
    always_comb begin : arb_search
        int cand;
        cand    = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        gnt_vec = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand = int'(last_q) + k;
            if (cand >= CHANNELS) begin
                cand = cand - CHANNELS;
            end
            if (!gnt_any && pend_v_q[IDX_W'(cand)]) begin
                gnt_any = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
        if (load && gnt_any) begin
            gnt_vec[gnt_idx] = 1'b1;
        end
    end

    // A granted slot clears this cycle; an edge in the same cycle refills it
    // without counting a drop, since the old content has been delivered.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_pol_d = pend_pol_q;
        drop_n     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (gnt_vec[i]) begin
                pend_v_d[i] = 1'b0;
            end
            if (edge_det[i]) begin
                pend_v_d[i]   = 1'b1;
                pend_pol_d[i] = level[i];
                if (pend_v_q[i] && !gnt_vec[i]) begin
                    drop_n = drop_n + 4'd1;
                end
            end
        end
    end

    always_comb begin
        drop_sum = {1'b0, drop_q} + {5'b0, drop_n};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    always_comb begin
        ev_valid_d = ev_valid_q;
        ev_chan_d  = ev_chan_q;
        ev_rise_d  = ev_rise_q;
        last_d     = last_q;
        if (load) begin
            ev_valid_d = gnt_any;
            if (gnt_any) begin
                ev_chan_d = 3'(gnt_idx);
                ev_rise_d = pend_pol_q[gnt_idx];
                last_d    = gnt_idx;
            end
        end
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            pend_v_q   <= '0;
            pend_pol_q <= '0;
            ev_valid_q <= 1'b0;
            ev_chan_q  <= '0;
            ev_rise_q  <= 1'b0;
            last_q     <= LAST_RST;
            drop_q     <= '0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_pol_q <= pend_pol_d;
            ev_valid_q <= ev_valid_d;
            ev_chan_q  <= ev_chan_d;
            ev_rise_q  <= ev_rise_d;
            last_q     <= last_d;
            drop_q     <= drop_d;
        end
    end

    assign ev_valid   = ev_valid_q;
    assign ev_chan    = ev_chan_q;
    assign ev_rise    = ev_rise_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_gate_event_arbiter.sv
// Testbench for gate_event_arbiter. Expected events are queued when the
// gate stimulus is applied and compared in order as handshakes occur.
// Build with GATE_DEBOUNCE_EN defined to exercise the debounce variant.

module tb_gate_event_arbiter;

    localparam int CH = 4;
`ifdef GATE_DEBOUNCE_EN
    localparam int DB = 16;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 4 + DB;
    localparam int GAP = (DB > 0) ? 40 : 10;

    typedef struct {
        logic [2:0] chan;
        logic       rise;
    } ev_t;

    logic          mclk = 1'b0;
    logic          rst;
    logic [CH-1:0] gate_in;
    logic          ev_valid;
    logic          ev_ready;
    logic [2:0]    ev_chan;
    logic          ev_rise;
    logic [CH-1:0] gate_level;
    logic [7:0]    drop_count;

    ev_t sb_q[$];
    int  n_total = 0;
    int  n_bad   = 0;
    int  n_hs    = 0;
    int  hs_mark;

    gate_event_arbiter #(
        .CHANNELS        (CH),
        .INIT_LEVEL      (1'b0),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .mclk       (mclk),
        .rst        (rst),
        .gate_in    (gate_in),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_chan    (ev_chan),
        .ev_rise    (ev_rise),
        .gate_level (gate_level),
        .drop_count (drop_count)
    );

    always #5 mclk = ~mclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic step();
        @(posedge mclk);
        @(negedge mclk);
    endtask

    task automatic drive_gate(input logic [CH-1:0] v);
        @(posedge mclk);
        #1 gate_in = v;
    endtask

    task automatic push_ev(input int c, input logic r);
        ev_t e;
        e.chan = 3'(c);
        e.rise = r;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge mclk);
        #1 rst = 1'b1;
        gate_in = '0;
        sb_q.delete();
        repeat (2) @(posedge mclk);
        #1 rst = 1'b0;
    endtask

    // Scoreboard side: every accepted event must match the head of the queue.
    always @(negedge mclk) begin
        if (!rst && ev_valid && ev_ready) begin
            n_hs++;
            if (sb_q.size() == 0) begin
                chk("spurious_ev", 32'(ev_valid & ev_ready), 32'd0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                chk("ev_chan", 32'(ev_chan), 32'(e.chan));
                chk("ev_rise", 32'(ev_rise), 32'(e.rise));
            end
        end
    end

    initial begin
        rst      = 1'b1;
        gate_in  = '0;
        ev_ready = 1'b1;

        // Reset state
        @(negedge mclk);
        @(negedge mclk);
        chk("rst_valid", 32'(ev_valid), 32'd0);
        chk("rst_chan", 32'(ev_chan), 32'd0);
        chk("rst_rise", 32'(ev_rise), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_level", 32'(gate_level), 32'd0);
        @(posedge mclk);
        #1 rst = 1'b0;
        repeat (3) @(posedge mclk);

        // Single rising edge on channel 2: exact latency, one-cycle pulse
        drive_gate(4'b0100);
        push_ev(2, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            chk("lat_valid", 32'(ev_valid), (k == LAT) ? 32'd1 : 32'd0);
            if (k == LAT) begin
                chk("lat_chan", 32'(ev_chan), 32'd2);
                chk("lat_rise", 32'(ev_rise), 32'd1);
            end
        end
        repeat (5) @(posedge mclk);
        drive_gate(4'b0000);
        push_ev(2, 1'b0);
        repeat (LAT + 5) @(posedge mclk);

        // All four channels rise together: channel 0 first, one per cycle
        do_reset();
        repeat (2) @(posedge mclk);
        drive_gate(4'b1111);
        for (int c = 0; c < CH; c++) push_ev(c, 1'b1);
        repeat (LAT - 1) step();
        for (int j = 0; j < CH; j++) begin
            step();
            chk("b2b_valid", 32'(ev_valid), 32'd1);
        end
        step();
        chk("b2b_idle", 32'(ev_valid), 32'd0);
        chk("b2b_drop", 32'(drop_count), 32'd0);
        chk("b2b_level", 32'(gate_level), 32'hF);
        drive_gate(4'b0000);
        for (int c = 0; c < CH; c++) push_ev(c, 1'b0);
        repeat (LAT + 8) @(posedge mclk);

        // Stalled consumer on channel 1. Channel 1 is first raised and
        // drained, then toggled 1->0->1->0->1: the fall is held in the
        // output register, the rise fills the slot, the next two edges
        // overwrite it.
        do_reset();
        repeat (2) @(posedge mclk);
        drive_gate(4'b0010);
        push_ev(1, 1'b1);
        repeat (LAT + 4) @(posedge mclk);
        #1 ev_ready = 1'b0;
        drive_gate(4'b0000);
        push_ev(1, 1'b0);
        repeat (GAP) @(posedge mclk);
        drive_gate(4'b0010);
        repeat (GAP) step();
        chk("stall_valid", 32'(ev_valid), 32'd1);
        chk("stall_chan", 32'(ev_chan), 32'd1);
        chk("stall_rise", 32'(ev_rise), 32'd0);
        drive_gate(4'b0000);
        repeat (GAP) step();
        chk("ovw1_drop", 32'(drop_count), 32'd1);
        drive_gate(4'b0010);
        push_ev(1, 1'b1);
        repeat (GAP) step();
        chk("ovw2_drop", 32'(drop_count), 32'd2);
        chk("ovw2_hold_chan", 32'(ev_chan), 32'd1);
        chk("ovw2_hold_rise", 32'(ev_rise), 32'd0);
        @(posedge mclk);
        #1 ev_ready = 1'b1;
        repeat (6) step();
        chk("stall_drained", 32'(ev_valid), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset while an event is presented and three slots are pending
        do_reset();
        #1 ev_ready = 1'b0;
        repeat (2) @(posedge mclk);
        drive_gate(4'b1111);
        repeat (LAT + 2) step();
        chk("pre_rst_valid", 32'(ev_valid), 32'd1);
        chk("pre_rst_chan", 32'(ev_chan), 32'd0);
        @(posedge mclk);
        #1 rst = 1'b1;
        gate_in = '0;
        sb_q.delete();
        @(posedge mclk);
        #1 rst = 1'b0;
        @(negedge mclk);
        chk("mid_rst_valid", 32'(ev_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        hs_mark = n_hs;
        #1 ev_ready = 1'b1;
        repeat (LAT + 30) @(posedge mclk);
        @(negedge mclk);
        chk("no_ev_after_rst", 32'(n_hs - hs_mark), 32'd0);

`ifndef GATE_DEBOUNCE_EN
        // Drop counter saturates instead of wrapping (598 overwrites)
        do_reset();
        #1 ev_ready = 1'b0;
        for (int t = 0; t < 600; t++) begin
            drive_gate((t % 2 == 0) ? 4'b1000 : 4'b0000);
            @(posedge mclk);
        end
        repeat (6) step();
        chk("drop_sat", 32'(drop_count), 32'd255);
        do_reset();
        #1 ev_ready = 1'b1;
`else
        // Debounce: a 10-cycle pulse is filtered, a 40-cycle pulse is not
        do_reset();
        #1 ev_ready = 1'b1;
        repeat (2) @(posedge mclk);
        hs_mark = n_hs;
        drive_gate(4'b0001);
        repeat (9) @(posedge mclk);
        drive_gate(4'b0000);
        repeat (40) @(posedge mclk);
        @(negedge mclk);
        chk("short_pulse", 32'(n_hs - hs_mark), 32'd0);
        drive_gate(4'b0001);
        push_ev(0, 1'b1);
        for (int k = 1; k <= LAT + 1; k++) begin
            step();
            chk("db_lat_valid", 32'(ev_valid), (k == LAT) ? 32'd1 : 32'd0);
        end
        repeat (39 - (LAT + 1)) @(posedge mclk);
        drive_gate(4'b0000);
        push_ev(0, 1'b0);
        repeat (LAT + 4) @(posedge mclk);
        @(negedge mclk);
        chk("long_pulse", 32'(n_hs - hs_mark), 32'd2);
`endif

        repeat (4) @(posedge mclk);
        chk("sb_end", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
